// File: rtl/fd_inst_queue_pkg.sv
// Shared CPU constants used by the fetch stage and the fetch/decode queue.
package fd_inst_queue_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fd_inst_queue.sv
// Fetch-to-decode instruction queue: a small circular FIFO of {PC, Instr}
// entries. Fetch is throttled through PC_RegWE, which depends only on the
// registered occupancy so that no combinational loop forms with fetch.
// Decode sees the head entry, or a NOP at RESET_PC when the queue is empty.
module fd_inst_queue
    import fd_inst_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        F_Valid,
    input  logic        D_Ready,
    input  logic        Flush,
    output logic        PC_RegWE,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic        D_Valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Handshake qualifiers; Flush overrides both push and pop.
    always_comb begin
        PC_RegWE = (count != CW'(DEPTH));
        D_Valid  = (count != '0);
        push     = F_Valid && PC_RegWE && !Flush;
        pop      = D_Valid && D_Ready && !Flush;
    end

    // Head entry presented to decode, NOP bubble when empty.
    always_comb begin
        D_PC    = RESET_PC;
        D_Instr = NOP_INSTR;
        if (D_Valid) begin
            D_PC    = pc_mem[rd_ptr];
            D_Instr = instr_mem[rd_ptr];
        end
    end

    // Entry storage; contents are left stale on flush/reset since count gates them.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr]    <= F_PC;
            instr_mem[wr_ptr] <= F_Instr;
        end
    end

    // Pointer and occupancy update; power-of-two depth makes wrap implicit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fd_inst_queue.sv
// Directed bench for fd_inst_queue (DEPTH=2): a table of single-cycle vectors
// checked one edge later, plus hand-written reset and stability sequences.
module tb_fd_inst_queue;

    logic        clk;
    logic        reset;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_Valid;
    logic        D_Ready;
    logic        Flush;
    logic        PC_RegWE;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_Valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fv;
        logic        rdy;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        ewe;
        string       name;
    } vec_t;

    vec_t vecs[$];

    fd_inst_queue #(.DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .F_PC     (F_PC),
        .F_Instr  (F_Instr),
        .F_Valid  (F_Valid),
        .D_Ready  (D_Ready),
        .Flush    (Flush),
        .PC_RegWE (PC_RegWE),
        .D_PC     (D_PC),
        .D_Instr  (D_Instr),
        .D_Valid  (D_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ei, input logic ewe);
        chk({name, ".D_Valid"},  {31'b0, D_Valid},  {31'b0, ev});
        chk({name, ".D_PC"},     D_PC,              epc);
        chk({name, ".D_Instr"},  D_Instr,           ei);
        chk({name, ".PC_RegWE"}, {31'b0, PC_RegWE}, {31'b0, ewe});
    endtask

    function automatic void add(input string name, input logic [31:0] pc, input logic [31:0] instr,
                                input logic fv, input logic rdy, input logic fl,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic ewe);
        vec_t v;
        v.name = name; v.pc = pc; v.instr = instr; v.fv = fv; v.rdy = rdy; v.fl = fl;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.ewe = ewe;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic fv, input logic rdy, input logic fl);
        F_PC = pc; F_Instr = instr; F_Valid = fv; D_Ready = rdy; Flush = fl;
    endtask

    initial begin
        // push then pop
        add("push1",   32'h3000, 32'h2401_0001, 1, 1, 0, 1, 32'h3000, 32'h2401_0001, 1);
        add("pop1",    32'h0,    32'h0,         0, 1, 0, 0, 32'h3000, 32'h0,         1);
        // fill under stall, third push ignored, drain in order
        add("fill0",   32'h3000, 32'hA000_0000, 1, 0, 0, 1, 32'h3000, 32'hA000_0000, 1);
        add("fill1",   32'h3004, 32'hA000_0004, 1, 0, 0, 1, 32'h3000, 32'hA000_0000, 0);
        add("fullign", 32'h3008, 32'hA000_0008, 1, 0, 0, 1, 32'h3000, 32'hA000_0000, 0);
        add("drain0",  32'h0,    32'h0,         0, 1, 0, 1, 32'h3004, 32'hA000_0004, 1);
        add("drain1",  32'h0,    32'h0,         0, 1, 0, 0, 32'h3000, 32'h0,         1);
        add("rdyempty",32'h0,    32'h0,         0, 1, 0, 0, 32'h3000, 32'h0,         1);
        // simultaneous push/pop streaming across pointer wraps
        add("strm0",   32'h3000, 32'hB000_3000, 1, 1, 0, 1, 32'h3000, 32'hB000_3000, 1);
        for (int k = 1; k <= 11; k++) begin
            add("strm", 32'h3000 + 32'(4 * k), 32'hB000_3000 + 32'(4 * k), 1, 1, 0,
                1, 32'h3000 + 32'(4 * k), 32'hB000_3000 + 32'(4 * k), 1);
        end
        add("strmend", 32'h0,    32'h0,         0, 1, 0, 0, 32'h3000, 32'h0,         1);
        // flush while full with a push pending
        add("ffill0",  32'h3100, 32'hC000_0000, 1, 0, 0, 1, 32'h3100, 32'hC000_0000, 1);
        add("ffill1",  32'h3104, 32'hC000_0004, 1, 0, 0, 1, 32'h3100, 32'hC000_0000, 0);
        add("flush",   32'h3010, 32'hDEAD_3010, 1, 0, 1, 0, 32'h3000, 32'h0,         1);
        add("postfl",  32'h0,    32'h0,         0, 1, 0, 0, 32'h3000, 32'h0,         1);
        // flush beats push into an empty, non-full queue
        add("flempty", 32'h3010, 32'hDEAD_3010, 1, 1, 1, 0, 32'h3000, 32'h0,         1);
        add("push2",   32'h3200, 32'hE000_0000, 1, 1, 0, 1, 32'h3200, 32'hE000_0000, 1);
        add("pop2",    32'h0,    32'h0,         0, 1, 0, 0, 32'h3000, 32'h0,         1);

        reset = 1'b1;
        drive(32'h0, 32'h0, 0, 0, 0);
        #1;
        chk_all("in_reset", 0, 32'h3000, 32'h0, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all("idle", 0, 32'h3000, 32'h0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].instr, vecs[i].fv, vecs[i].rdy, vecs[i].fl);
            @(posedge clk); #1;
            chk_all($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].ev, vecs[i].epc,
                    vecs[i].einstr, vecs[i].ewe);
        end

        // Full: PC_RegWE must not react combinationally to F_Valid/Flush/D_Ready.
        @(negedge clk); drive(32'h3300, 32'hF000_0000, 1, 0, 0);
        @(negedge clk); drive(32'h3304, 32'hF000_0004, 1, 0, 0);
        @(negedge clk); drive(32'h3308, 32'hF000_0008, 0, 1, 1);
        #1;
        chk_all("comb_indep", 1, 32'h3300, 32'hF000_0000, 0);
        drive(32'h3308, 32'hF000_0008, 1, 0, 0);

        // Asynchronous reset mid-cycle with two entries queued.
        @(posedge clk); #2;
        chk_all("pre_areset", 1, 32'h3300, 32'hF000_0000, 0);
        reset = 1'b1;
        #1;
        chk_all("areset_now", 0, 32'h3000, 32'h0, 1);
        drive(32'h3400, 32'h1111_0000, 1, 1, 0);
        @(posedge clk); #1;
        chk_all("reset_hold", 0, 32'h3000, 32'h0, 1);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0, 32'h0, 0, 1, 0);
        @(posedge clk); #1;
        chk_all("post_reset", 0, 32'h3000, 32'h0, 1);
        @(negedge clk); drive(32'h3500, 32'h2222_0000, 1, 0, 0);
        @(posedge clk); #1;
        chk_all("resume", 1, 32'h3500, 32'h2222_0000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_inst_queue.md
FD_INST_QUEUE -- requirements
Module: fd_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queue entries; legal values are powers of two, 2..8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port F_PC, input, 32 bits: PC of the fetched instruction, from the fetch-stage PC register.
REQ-005 SHALL have port F_Instr, input, 32 bits: instruction word at F_PC.
REQ-006 SHALL have port F_Valid, input, 1 bit: fetch presents a valid instruction this cycle.
REQ-007 SHALL have port D_Ready, input, 1 bit: decode accepts the head entry this cycle; low means decode stall.
REQ-008 SHALL have port Flush, input, 1 bit: discard all queued and incoming instructions.
REQ-009 SHALL have port PC_RegWE, output, 1 bit: fetch-PC write enable; high means the queue can accept a push.
REQ-010 SHALL have port D_PC, output, 32 bits: PC of the head entry.
REQ-011 SHALL have port D_Instr, output, 32 bits: instruction of the head entry.
REQ-012 SHALL have port D_Valid, output, 1 bit: head entry is valid.

Function
REQ-013 SHALL implement a circular FIFO of DEPTH entries holding {PC, Instr}, with read pointer, write pointer, and an occupancy count of log2(DEPTH)+1 bits.
REQ-014 SHALL drive PC_RegWE = (count != DEPTH), combinationally from registered state only, with no path from F_Valid, D_Ready or Flush.
REQ-015 SHALL push on a rising edge when F_Valid && PC_RegWE && !Flush: write entry at the write pointer, advance it modulo DEPTH, and increment count.
REQ-016 SHALL pop on a rising edge when D_Valid && D_Ready && !Flush: advance the read pointer modulo DEPTH and decrement count.
REQ-017 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-018 SHALL make push impossible while full; the full case is entered only via PC_RegWE=0, so an F_Valid arriving then is ignored and fetch holds its PC.
REQ-019 SHALL make pop impossible while empty; D_Ready while empty has no effect.
REQ-020 SHALL drive D_Valid = (count != 0).
REQ-021 SHALL drive D_PC and D_Instr combinationally from the entry at the read pointer when D_Valid is high.
REQ-022 SHALL drive D_Instr = 32'h00000000 (NOP) and D_PC = 32'h00003000 when the queue is empty.
REQ-023 SHALL make the data of an entry pushed at edge N visible at D_* after edge N, giving one cycle latency from F to D.
REQ-024 SHALL give Flush priority over push and pop: at the edge, clear count and both pointers, and drop the simultaneous push; entry contents need not be cleared.
REQ-025 SHALL keep outputs stable while D_Ready is low and no Flush occurs, for any F activity.
REQ-026 SHALL keep pointer wrap-around transparent, so FIFO order is preserved across any number of wraps.

Reset
REQ-027 SHALL clear count, read pointer and write pointer to 0 immediately on reset assertion, independent of clk.
REQ-028 SHALL, in reset, drive D_Valid=0, D_Instr=32'h00000000, D_PC=32'h00003000 and PC_RegWE=1.
REQ-029 SHALL ignore push, pop and Flush while reset is high; operation resumes at the first rising edge after deassertion.
REQ-030 SHALL treat reset asserted mid-operation, with the queue partly full, as discarding all entries.

Structure
REQ-031 SHALL take the constants RESET_PC (32'h00003000) and NOP_INSTR (32'h00000000) from the shared CPU package, which the fetch stage uses as well.
REQ-032 SHALL be implemented as a single flat module with no sub-module; storage is a DEPTH-entry register array plus pointer and count registers.

Verification
REQ-033 SHALL be verified with these directed scenarios:
- Reset then idle: D_Valid=0, D_PC=0x3000, D_Instr=0, PC_RegWE=1.
- Push and pop: push {0x3000, 0x24010001} with D_Ready=1 -> next cycle D_Valid=1, D_PC=0x3000, D_Instr=0x24010001, then pop -> empty.
- Fill under stall: D_Ready=0, push 0x3000 then 0x3004 -> PC_RegWE=0. A third push of 0x3008 is ignored; then D_Ready=1 drains in order 0x3000, 0x3004.
- Simultaneous push and pop with count=1 -> count stays 1; head advances from 0x3000 to 0x3004. Run 10 cycles continuously to cross a pointer wrap, with PCs strictly sequential.
- Flush while full with push of 0x3010 asserted -> next cycle empty, D_Valid=0, PC_RegWE=1; 0x3010 never appears at D_*.
- Asynchronous reset mid-cycle with count=2 -> D_Valid=0 and PC_RegWE=1 before the next edge.
